// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared constants and types for the MD5 message padder
package md5_pkg;

  localparam int BLK_BITS  = 512;
  localparam int BLK_BYTES = 64;
  localparam int LEN_OFS   = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_FILL,
    S_SEND,
    S_EXTRA
  } md5_state_t;

  typedef logic [BLK_BITS-1:0] md5_blk_t;

endpackage

// File: rtl/md5_len_field.sv
// rtl/md5_len_field.sv - formats the 64-bit message bit length into block bytes 56..63
// MD5_PAD_BE_EN selects big-endian (byte 56 = MSB); default is MD5 little-endian.
module md5_len_field (
  input  logic [63:0] len_bits,
  output logic [63:0] field
);

`ifdef MD5_PAD_BE_EN
  for (genvar i = 0; i < 8; i++) begin : g_swap
    assign field[8*i +: 8] = len_bits[8*(7-i) +: 8];
  end
`else
  assign field = len_bits;
`endif

endmodule

// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - packs a byte stream into padded 512-bit MD5 blocks with first/final flags
// MD5_PAD_BE_EN selects SHA-style input byte order and big-endian length field.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*IN_BYTES-1:0]         in_data,
  input  logic                          in_last,
  input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [BLK_BITS-1:0]           blk_data,
  output logic                          blk_first,
  output logic                          blk_final,
  output logic                          busy
);

  localparam int NB_W = $clog2(IN_BYTES+1);

  md5_state_t       state;
  logic [6:0]       ptr;
  logic [LEN_W-1:0] len;
  logic [63:0]      len_bits_q;
  logic             first_pend;
  logic             extra_pend;
  logic             marker_pend;

  logic [6:0]       nb;
  logic [6:0]       p;
  logic [LEN_W-1:0] len_new;
  logic [LEN_W+2:0] len_x8;
  logic [63:0]      new_bits;
  logic [63:0]      len_src;
  logic [63:0]      len_field;
  md5_blk_t         fill_blk;
  md5_blk_t         extra_blk;

  function automatic logic [7:0] in_byte(input logic [8*IN_BYTES-1:0] d, input int k);
`ifdef MD5_PAD_BE_EN
    return d[8*(IN_BYTES-k)-1 -: 8];
`else
    return d[8*k +: 8];
`endif
  endfunction

  always_comb begin
    nb = 7'(IN_BYTES);
    if (in_last && (in_nbytes < NB_W'(IN_BYTES)))
      nb = 7'(in_nbytes);
  end

  assign p        = ptr + nb;
  assign len_new  = len + LEN_W'(nb);
  assign len_x8   = {len_new, 3'b000};
  assign new_bits = 64'(len_x8);
  assign len_src  = (state == S_EXTRA) ? len_bits_q : new_bits;

  md5_len_field u_len_field (
    .len_bits (len_src),
    .field    (len_field)
  );

  // Block after the current beat; bytes past the write point are already zero.
  always_comb begin
    fill_blk = blk_data;
    for (int k = 0; k < IN_BYTES; k++) begin
      if (7'(k) < nb)
        fill_blk[8*(int'(ptr)+k) +: 8] = in_byte(in_data, k);
    end
    if (in_last) begin
      if (p < 7'(BLK_BYTES))
        fill_blk[8*int'(p) +: 8] = PAD_BYTE;
      if (p < 7'(LEN_OFS))
        fill_blk[8*LEN_OFS +: 64] = len_field;
    end
  end

  always_comb begin
    extra_blk = '0;
    if (marker_pend)
      extra_blk[7:0] = PAD_BYTE;
    extra_blk[8*LEN_OFS +: 64] = len_field;
  end

  assign busy = (state != S_FILL) || (ptr != 7'd0) || !first_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FILL;
      ptr         <= '0;
      len         <= '0;
      len_bits_q  <= '0;
      first_pend  <= 1'b1;
      extra_pend  <= 1'b0;
      marker_pend <= 1'b0;
      in_ready    <= 1'b1;
      blk_valid   <= 1'b0;
      blk_data    <= '0;
      blk_first   <= 1'b0;
      blk_final   <= 1'b0;
    end else if (abort) begin
      state       <= S_FILL;
      ptr         <= '0;
      len         <= '0;
      len_bits_q  <= '0;
      first_pend  <= 1'b1;
      extra_pend  <= 1'b0;
      marker_pend <= 1'b0;
      in_ready    <= 1'b1;
      blk_valid   <= 1'b0;
      blk_data    <= '0;
      blk_first   <= 1'b0;
      blk_final   <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid && in_ready) begin
            blk_data <= fill_blk;
            ptr      <= p;
            len      <= len_new;
            if (in_last || (p == 7'(BLK_BYTES))) begin
              state       <= S_SEND;
              in_ready    <= 1'b0;
              blk_valid   <= 1'b1;
              blk_first   <= first_pend;
              blk_final   <= in_last && (p < 7'(LEN_OFS));
              extra_pend  <= in_last && (p >= 7'(LEN_OFS));
              marker_pend <= in_last && (p == 7'(BLK_BYTES));
              if (in_last)
                len_bits_q <= new_bits;
            end
          end
        end
        S_SEND: begin
          if (blk_ready) begin
            blk_valid  <= 1'b0;
            first_pend <= 1'b0;
            if (extra_pend) begin
              state <= S_EXTRA;
            end else begin
              state     <= S_FILL;
              in_ready  <= 1'b1;
              blk_data  <= '0;
              ptr       <= '0;
              blk_first <= 1'b0;
              blk_final <= 1'b0;
              if (blk_final) begin
                len        <= '0;
                first_pend <= 1'b1;
              end
            end
          end
        end
        S_EXTRA: begin
          blk_data    <= extra_blk;
          blk_first   <= 1'b0;
          blk_final   <= 1'b1;
          blk_valid   <= 1'b1;
          extra_pend  <= 1'b0;
          marker_pend <= 1'b0;
          state       <= S_SEND;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - self-checking bench for md5_msg_padder (IN_BYTES=4)
module tb_md5_msg_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         fin;
  } blk_rec_t;
  typedef blk_rec_t blk_q_t[$];
  typedef struct {
    int          len;
    bit          zero_last;
    int          nblk;
    logic [63:0] lenbits;
  } vec_t;

  logic         clk = 0;
  logic         reset_n = 0;
  logic         abort = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 0;
  logic [2:0]   in_nbytes = '0;
  logic         blk_valid;
  logic         blk_ready = 0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_final;
  logic         busy;

  int n_vec = 0;
  int n_miss = 0;
  int rdy_mode = 0;
  int gap_max = 0;
  blk_rec_t cap_q[$];

  md5_msg_padder #(.IN_BYTES(4), .LEN_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_final(blk_final), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: blk_ready = 1'b1;
      1: blk_ready = 1'($urandom_range(0, 1));
      default: blk_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    blk_rec_t r;
    if (reset_n && !abort && blk_valid && blk_ready) begin
      r.data = blk_data; r.first = blk_first; r.fin = blk_final;
      cap_q.push_back(r);
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: standard MD5 padding of the whole message, then cut into 64-byte blocks.
  task automatic model(input byte_q_t msg, output blk_q_t exp);
    byte_q_t q;
    logic [63:0] bits;
    blk_rec_t r;
    q = msg;
    bits = 64'(msg.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
`ifdef MD5_PAD_BE_EN
      q.push_back(bits[8*(7-i) +: 8]);
`else
      q.push_back(bits[8*i +: 8]);
`endif
    end
    exp = {};
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int i = 0; i < 64; i++) r.data[8*i +: 8] = q[64*b + i];
      r.first = (b == 0);
      r.fin = (b == q.size() / 64 - 1);
      exp.push_back(r);
    end
  endtask

  function automatic logic [31:0] pack(input byte_q_t m, input int base, input int n);
    logic [31:0] d = '0;
    for (int k = 0; k < n; k++) begin
`ifdef MD5_PAD_BE_EN
      d[8*(4-k)-1 -: 8] = m[base + k];
`else
      d[8*k +: 8] = m[base + k];
`endif
    end
    return d;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic last, input int n);
    int cnt = 0;
    bit acc = 0;
    in_data = d; in_last = last; in_nbytes = 3'(n); in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      cnt++;
    end while (!acc && cnt < 2000);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      n_vec++; n_miss++;
      $display("FAIL beat_accept: in_ready got 0 expected 1 within 2000 cycles");
    end
  endtask

  task automatic send_beats(input byte_q_t msg, input bit zero_last);
    int len = msg.size();
    int pos = 0;
    if (len == 0) drive_beat('0, 1'b1, 0);
    while (pos < len) begin
      int n = (len - pos >= 4) ? 4 : len - pos;
      bit last = (pos + n == len) && !(zero_last && n == 4);
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      drive_beat(pack(msg, pos, n), last, n);
      pos += n;
    end
    if (len > 0 && zero_last && len % 4 == 0) drive_beat('0, 1'b1, 0);
  endtask

  task automatic check_blocks(input string nm, input byte_q_t msg);
    blk_q_t exp;
    int t = 0;
    model(msg, exp);
    while (cap_q.size() < exp.size() && t < 1000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    chk({nm, "_nblk"}, 512'(cap_q.size()), 512'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), cap_q[i].data, exp[i].data);
      chk($sformatf("%s_first%0d", nm, i), 512'(cap_q[i].first), 512'(exp[i].first));
      chk($sformatf("%s_final%0d", nm, i), 512'(cap_q[i].fin), 512'(exp[i].fin));
    end
    @(posedge clk); #1;
  endtask

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t m = {};
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  initial begin
    vec_t tbl[10];
    byte_q_t m;
    logic [511:0] snap;
    bit stable;
    bit rdy_low;
    int t;

    tbl[0] = '{0,   0, 1, 64'd0};
    tbl[1] = '{3,   0, 1, 64'd24};
    tbl[2] = '{55,  0, 1, 64'd440};
    tbl[3] = '{56,  0, 2, 64'd448};
    tbl[4] = '{63,  0, 2, 64'd504};
    tbl[5] = '{64,  0, 2, 64'd512};
    tbl[6] = '{64,  1, 2, 64'd512};
    tbl[7] = '{65,  0, 2, 64'd520};
    tbl[8] = '{119, 0, 2, 64'd952};
    tbl[9] = '{120, 1, 3, 64'd960};

    #12;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    chk("rst_flags", 512'({blk_first, blk_final, busy}), 512'(0));
    reset_n = 1;
    @(posedge clk); #1;

    // Empty message
    cap_q = {};
    m = {};
    send_beats(m, 0);
    check_blocks("empty", m);
    if (cap_q.size() > 0) chk("empty_bytes", cap_q[0].data, 512'h80);

    // "abc"
    cap_q = {};
    m = {8'h61, 8'h62, 8'h63};
    send_beats(m, 0);
    check_blocks("abc", m);
    if (cap_q.size() > 0) begin
      chk("abc_low", 512'(cap_q[0].data[31:0]), 512'(32'h80636261));
      chk("abc_len", 512'(cap_q[0].data[511:448]), 512'(64'h18));
    end

    // Length table with boundary sizes
    for (int i = 0; i < 10; i++) begin
      cap_q = {};
      m = rand_msg(tbl[i].len);
      send_beats(m, tbl[i].zero_last);
      check_blocks($sformatf("tbl%0d", i), m);
      chk($sformatf("tbl%0d_count", i), 512'(cap_q.size()), 512'(tbl[i].nblk));
      if (cap_q.size() > 0) begin
        chk($sformatf("tbl%0d_lenfield", i), 512'(cap_q[cap_q.size()-1].data[511:448]),
            512'(tbl[i].lenbits));
        if (tbl[i].len == 56) chk("b56_marker", 512'(cap_q[0].data[455:448]), 512'(8'h80));
        if (tbl[i].len == 64) chk("b64_marker", 512'(cap_q[1].data[7:0]), 512'(8'h80));
      end
    end
    chk("idle_busy", 512'(busy), 512'(0));

    // Back-pressure: hold blk_ready low 10 cycles while the next beat waits
    cap_q = {};
    m = rand_msg(68);
    rdy_mode = 2;
    fork
      send_beats(m, 0);
      begin
        t = 0;
        while (!blk_valid && t < 500) begin @(negedge clk); t++; end
        snap = blk_data;
        stable = 1; rdy_low = 1;
        repeat (10) begin
          @(negedge clk);
          if (blk_data !== snap || !blk_valid) stable = 0;
          if (in_ready !== 1'b0) rdy_low = 0;
        end
        chk("stall_valid_seen", 512'(t < 500), 512'(1));
        chk("stall_data_stable", 512'(stable), 512'(1));
        chk("stall_in_ready_low", 512'(rdy_low), 512'(1));
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    check_blocks("stall", m);

    // Abort mid-message, then "a"
    cap_q = {};
    drive_beat(32'h44332211, 1'b0, 4);
    drive_beat(32'h88776655, 1'b0, 4);
    abort = 1; @(posedge clk); #1; abort = 0;
    m = {8'h61};
    send_beats(m, 0);
    check_blocks("abort_a", m);
    if (cap_q.size() > 0) begin
      chk("abort_a_low", 512'(cap_q[0].data[15:0]), 512'(16'h8061));
      chk("abort_a_len", 512'(cap_q[0].data[511:448]), 512'(64'h8));
    end

    // Asynchronous reset pulse mid-block
    cap_q = {};
    drive_beat(32'hdeadbeef, 1'b0, 4);
    drive_beat(32'hcafef00d, 1'b0, 4);
    #2 reset_n = 0;
    #4;
    chk("rstpulse_in_ready", 512'(in_ready), 512'(1));
    chk("rstpulse_busy", 512'(busy), 512'(0));
    #7 reset_n = 1;
    repeat (20) @(negedge clk);
    chk("rstpulse_no_blocks", 512'(cap_q.size()), 512'(0));
    @(posedge clk); #1;

    // Randomized messages, random back-pressure and input gaps
    gap_max = 2;
    for (int r = 0; r < 20; r++) begin
      cap_q = {};
      rdy_mode = $urandom_range(0, 1);
      m = rand_msg($urandom_range(0, 200));
      send_beats(m, 1'($urandom_range(0, 1)));
      check_blocks($sformatf("rnd%0d", r), m);
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
